// File: rtl/banked_sync_ram_if.sv
// banked_sync_ram_if: valid/ready request and fixed-latency response bus for banked_sync_ram
interface banked_sync_ram_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic                  rsp_valid;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  rsp_err;
    modport master (
        output req_valid, req_we, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );
    modport slave (
        input  req_valid, req_we, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/banked_sync_ram.sv
// banked_sync_ram: banked single-port RAM with post-reset clear sweep and 1-cycle read response.
// Define BANKED_RAM_PARITY_EN to store an even-parity bit per word and flag mismatches on rsp_err.
module banked_sync_ram #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8,
    parameter int NUM_BANKS  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    banked_sync_ram_if.slave bus,
    output logic             init_done
);
    localparam int BANK_BITS = $clog2(NUM_BANKS);
    localparam int OFF_BITS  = ADDR_WIDTH - BANK_BITS;
    localparam int DEPTH     = 2 ** OFF_BITS;
`ifdef BANKED_RAM_PARITY_EN
    localparam int MEM_WIDTH = DATA_WIDTH + 1;
`else
    localparam int MEM_WIDTH = DATA_WIDTH;
`endif
    typedef enum logic {INIT, RUN} state_t;
    state_t                state, state_nxt;
    logic [OFF_BITS-1:0]   clr_ptr;
    logic [MEM_WIDTH-1:0]  mem [NUM_BANKS][DEPTH];
    logic [BANK_BITS-1:0]  bank;
    logic [OFF_BITS-1:0]   offset;
    logic [NUM_BANKS-1:0]  bank_sel;
    logic                  fire, wr_fire, rd_fire;
    logic [MEM_WIDTH-1:0]  wr_word, rd_word;
    assign bank     = bus.req_addr[ADDR_WIDTH-1 -: BANK_BITS];
    assign offset   = bus.req_addr[OFF_BITS-1:0];
    assign bank_sel = NUM_BANKS'(1) << bank;
    assign fire     = bus.req_valid & bus.req_ready;
    assign wr_fire  = fire & bus.req_we;
    assign rd_fire  = fire & ~bus.req_we;
    assign rd_word  = mem[bank][offset];
`ifdef BANKED_RAM_PARITY_EN
    assign wr_word = {^bus.req_wdata, bus.req_wdata};
`else
    assign wr_word = bus.req_wdata;
`endif
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= INIT;
        else        state <= state_nxt;
    always_comb state_nxt = (state == INIT && &clr_ptr) ? RUN : state;
    always_comb begin
        bus.req_ready = state == RUN;
        init_done     = state == RUN;
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)              clr_ptr <= '0;
        else if (state == INIT)  clr_ptr <= clr_ptr + 1'b1;
    // Sweep clears one offset in every bank at once; in RUN only the decoded bank is enabled
    always_ff @(posedge clk)
        for (int b = 0; b < NUM_BANKS; b++)
            if (state == INIT)                 mem[b][clr_ptr] <= '0;
            else if (wr_fire && bank_sel[b])   mem[b][offset]  <= wr_word;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            bus.rsp_valid <= 1'b0;
            bus.rsp_rdata <= '0;
        end else begin
            bus.rsp_valid <= rd_fire;
            if (rd_fire) bus.rsp_rdata <= rd_word[DATA_WIDTH-1:0];
        end
`ifdef BANKED_RAM_PARITY_EN
    // XOR over data plus stored parity is nonzero exactly when they disagree
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) bus.rsp_err <= 1'b0;
        else        bus.rsp_err <= rd_fire & ^rd_word;
`else
    assign bus.rsp_err = 1'b0;
`endif
endmodule

// File: tb/tb_banked_sync_ram.sv
// tb_banked_sync_ram: directed scoreboard bench for banked_sync_ram (4 banks x 64 words x 8 bits)
module tb_banked_sync_ram;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic init_done;
    always #5 clk = ~clk;
    banked_sync_ram_if #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) bus ();
    banked_sync_ram #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .NUM_BANKS(4)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .init_done(init_done)
    );
    typedef struct packed {logic [7:0] d; logic e;} exp_t;
    exp_t       q[$];
    logic [7:0] mm [256];
    logic       me [256];
    logic [7:0] last_rd;
    int         init_left = 0;
    int         checks = 0, passed = 0, fails = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        foreach (mm[i]) begin
            mm[i] = 8'h00;
            me[i] = 1'b0;
        end
        last_rd = 8'h00;
    endtask

    // One request cycle: drive at negedge, check the response at the following negedge
    task automatic step(input logic v, input logic we, input logic [7:0] a, input logic [7:0] d);
        logic acc;
        exp_t e;
        bus.req_valid = v;
        bus.req_we    = we;
        bus.req_addr  = a;
        bus.req_wdata = d;
        chk("req_ready", bus.req_ready, init_left == 0);
        chk("init_done", init_done, init_left == 0);
        acc = v && init_left == 0;
        if (acc && !we) q.push_back({mm[a], me[a]});
        if (acc && we) begin
            mm[a] = d;
            me[a] = 1'b0;
        end
        @(posedge clk);
        if (init_left > 0) init_left--;
        @(negedge clk);
        bus.req_valid = 1'b0;
        chk("rsp_valid", bus.rsp_valid, acc && !we);
        if (bus.rsp_valid && q.size() > 0) begin
            e = q.pop_front();
            chk("rsp_rdata", bus.rsp_rdata, e.d);
            chk("rsp_err", bus.rsp_err, e.e);
            last_rd = e.d;
        end else if (!bus.rsp_valid) begin
            chk("rdata_hold", bus.rsp_rdata, last_rd);
            chk("err_idle", bus.rsp_err, 1'b0);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.req_valid = 1'b0;
        model_reset();
        #1;
        chk("rst_ready", bus.req_ready, 1'b0);
        chk("rst_valid", bus.rsp_valid, 1'b0);
        chk("rst_rdata", bus.rsp_rdata, 8'h00);
        chk("rst_err", bus.rsp_err, 1'b0);
        chk("rst_init_done", init_done, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        init_left = 64;
    endtask

    task automatic rd(input logic [7:0] a);
        step(1'b1, 1'b0, a, 8'h00);
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        step(1'b1, 1'b1, a, d);
    endtask

    initial begin
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        @(negedge clk);
        do_reset();
        // INIT sweep with requests presented mid-sweep that must be ignored
        for (int i = 0; i < 64; i++) begin
            if (i == 20)      wr(8'h7F, 8'hEE);
            else if (i == 21) rd(8'h7F);
            else              step(1'b0, 1'b0, 8'h00, 8'h00);
        end
        rd(8'h00);
        rd(8'h7F);
        rd(8'hFF);
        // Same offset in all four banks
        wr(8'h03, 8'hA5);
        wr(8'h43, 8'h5A);
        wr(8'h83, 8'h3C);
        wr(8'hC3, 8'hC3);
        rd(8'h03);
        rd(8'h43);
        rd(8'h83);
        rd(8'hC3);
        step(1'b0, 1'b0, 8'h00, 8'h00);
        // Read followed by a write to the same address
        wr(8'h10, 8'h11);
        rd(8'h10);
        wr(8'h10, 8'h99);
        rd(8'h10);
        rd(8'h04);
`ifdef BANKED_RAM_PARITY_EN
        wr(8'h20, 8'h07);
        step(1'b0, 1'b0, 8'h00, 8'h00);
        dut.mem[0][32][0] = ~dut.mem[0][32][0];
        mm[8'h20] = 8'h06;
        me[8'h20] = 1'b1;
        rd(8'h20);
        rd(8'h03);
`endif
        // Reset arriving right after a read is accepted drops its response
        wr(8'h05, 8'h77);
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b0;
        bus.req_addr  = 8'h05;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        bus.req_valid = 1'b0;
        #1;
        chk("rsp_dropped", bus.rsp_valid, 1'b0);
        @(negedge clk);
        do_reset();
        for (int i = 0; i < 64; i++) step(1'b0, 1'b0, 8'h00, 8'h00);
        rd(8'h05);
        rd(8'hC3);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
